bus_responder: RTL and testbench

Memory-side responder for the 65C02 microcode core's address/data bus. Samples the CPU's 16-bit address (ABH:ABL), write enable and write data, and serves a single-port synchronous RAM. Returns read data on DB one cycle later. Inserts programmable wait states for one address page by deasserting `rdy`. It is the far end of the address bus that the core's ABL/ABH logic drives, and it is the source of the core's `rdy` input.

---
 rtl/bus_pkg.sv | 8 +
 rtl/ram_sp.sv | 16 +
 rtl/bus_responder.sv | 66 ++++++
 tb/tb_bus_responder.sv | 139 +++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// bus_pkg: shared FSM state type, bus widths and default wait-state settings for bus_responder
package bus_pkg;
   localparam int ADDR_W = 16;
   localparam int DATA_W = 8;
   localparam logic [7:0] DEF_SLOW_PAGE = 8'hD0;
   localparam int DEF_WAIT = 2;
   typedef enum logic {IDLE, WAITING} state_t;
endpackage

// File: rtl/ram_sp.sv
// ram_sp: write-first single-port sync RAM; clk, we, addr[MEM_AW-1:0], din[7:0] in, dout[7:0] out
module ram_sp #(
   parameter int MEM_AW = 16
) (
   input  logic              clk,
   input  logic              we,
   input  logic [MEM_AW-1:0] addr,
   input  logic [7:0]        din,
   output logic [7:0]        dout
);
   logic [7:0] mem [2**MEM_AW];
   always_ff @(posedge clk) begin
      if (we) mem[addr] <= din;
      dout <= we ? din : mem[addr];
   end
endmodule

// File: rtl/bus_responder.sv
// bus_responder: 65C02 bus RAM responder with page wait states; clk/RST/AB/WE/DO in, DB/rdy/busy out
module bus_responder
   import bus_pkg::*;
#(
   parameter int         MEM_AW    = ADDR_W,
   parameter logic [7:0] SLOW_PAGE = DEF_SLOW_PAGE,
   parameter int         WAIT      = DEF_WAIT
) (
   input  logic              clk,
   input  logic              RST,
   input  logic [ADDR_W-1:0] AB,
   input  logic              WE,
   input  logic [DATA_W-1:0] DO,
   output logic [DATA_W-1:0] DB,
   output logic              rdy,
   output logic              busy
);
   localparam logic [3:0] WAIT_C = 4'(WAIT);
   state_t state, state_nx;
   logic [3:0] cnt;
   logic [ADDR_W-1:0] A_q;
   logic W_q;
   logic [DATA_W-1:0] D_q;
   logic slow, last, ram_we, rd_now, rd_q;
   logic [MEM_AW-1:0] ram_addr;
   logic [DATA_W-1:0] ram_din, ram_dout, db_q;
   assign slow = AB[15:8] == SLOW_PAGE && WAIT != 0;
   assign last = state == WAITING && cnt == 4'd1;
   always_ff @(posedge clk) state <= RST ? IDLE : state_nx;
   always_comb state_nx = state == IDLE ? (slow ? WAITING : IDLE) : (last ? IDLE : WAITING);
   always_comb begin
      ram_addr = state == WAITING ? A_q[MEM_AW-1:0] : AB[MEM_AW-1:0];
      ram_din  = state == WAITING ? D_q : DO;
      ram_we   = ~RST & (state == IDLE ? WE & ~slow : last & W_q);
      rd_now   = state == IDLE ? ~WE & ~slow : last & ~W_q;
   end
   always_ff @(posedge clk) begin
      if (RST) begin
         cnt  <= '0;
         rdy  <= 1'b1;
         rd_q <= 1'b0;
         db_q <= '0;
         W_q  <= 1'b0;
      end else begin
         cnt  <= state == IDLE ? (slow ? WAIT_C : '0) : cnt - 4'd1;
         rdy  <= state_nx == IDLE;
         rd_q <= rd_now;
         db_q <= DB;
         if (state == IDLE) begin
            A_q <= AB;
            W_q <= WE;
            D_q <= DO;
         end
      end
   end
   // RAM output is only valid the cycle after a read; otherwise DB shows the held copy
   assign DB = rd_q ? ram_dout : db_q;
   assign busy = ~rdy;
   ram_sp #(.MEM_AW(MEM_AW)) u_ram (
      .clk (clk),
      .we  (ram_we),
      .addr(ram_addr),
      .din (ram_din),
      .dout(ram_dout)
   );
endmodule

// File: tb/tb_bus_responder.sv
// tb_bus_responder: directed and model-based checks of bus_responder timing, data and wait states
module tb_bus_responder;
   logic clk = 0, RST = 1, WE = 0;
   logic [15:0] AB = '0;
   logic [7:0] DO = '0;
   logic [7:0] DB, db_w0, db_aw;
   logic rdy, busy, rdy_w0, busy_w0, rdy_aw, busy_aw;
   int total = 0, bad = 0, w0_low = 0, n;
   logic [7:0] mf [16], ms [16];
   logic [7:0] last_db, exp_db;
   always #5 clk = ~clk;
   bus_responder u_dut (.clk(clk), .RST(RST), .AB(AB), .WE(WE), .DO(DO), .DB(DB), .rdy(rdy), .busy(busy));
   bus_responder #(.WAIT(0)) u_w0 (.clk(clk), .RST(RST), .AB(AB), .WE(WE), .DO(DO), .DB(db_w0), .rdy(rdy_w0), .busy(busy_w0));
   bus_responder #(.MEM_AW(12), .WAIT(0)) u_aw (.clk(clk), .RST(RST), .AB(AB), .WE(WE), .DO(DO), .DB(db_aw), .rdy(rdy_aw), .busy(busy_aw));
   always @(negedge clk) if (!RST && rdy_w0 !== 1'b1) w0_low++;
   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask
   task automatic drive(input logic [15:0] a, input logic w, input logic [7:0] d);
      AB = a;
      WE = w;
      DO = d;
      @(negedge clk);
   endtask
   task automatic wait_rdy(output int c);
      c = 0;
      while (rdy !== 1'b1 && c < 40) begin
         c++;
         @(negedge clk);
      end
   endtask
   initial begin
      repeat (2) @(negedge clk);
      chk("rst_rdy", rdy, 1);
      chk("rst_busy", busy, 0);
      chk("rst_db", DB, 8'h00);
      RST = 0;
      drive(16'h0200, 1, 8'h5A);
      chk("fw_rdy", rdy, 1);
      chk("fw_db_hold", DB, 8'h00);
      drive(16'h0200, 0, 8'h00);
      chk("fr_rdy", rdy, 1);
      chk("fr_db", DB, 8'h5A);
      drive(16'hD010, 1, 8'hC3);
      wait_rdy(n);
      chk("pre_waits", n, 2);
      chk("pre_db_hold", DB, 8'h5A);
      drive(16'hD010, 0, 8'h00);
      chk("sr_busy1", busy, 1);
      chk("sr_rdy1", rdy, 0);
      AB = 16'h0200; WE = 1; DO = 8'hEE;
      @(negedge clk);
      chk("sr_rdy2", rdy, 0);
      chk("sr_db_hold", DB, 8'h5A);
      AB = 16'h0010; WE = 0;
      @(negedge clk);
      chk("sr_rdy3", rdy, 1);
      chk("sr_db", DB, 8'hC3);
      drive(16'h0200, 0, 8'h00);
      chk("sr_ignored_ab", DB, 8'h5A);
      drive(16'h0001, 1, 8'h42);
      drive(16'hD001, 1, 8'h77);
      wait_rdy(n);
      chk("sw_waits", n, 2);
      drive(16'hD001, 0, 8'h00);
      wait_rdy(n);
      chk("sw_rd_waits", n, 2);
      chk("sw_rd_db", DB, 8'h77);
      drive(16'h0001, 0, 8'h00);
      chk("sw_alias_db", DB, 8'h42);
      drive(16'hD020, 1, 8'h9C);
      wait_rdy(n);
      drive(16'hD020, 1, 8'hFF);
      chk("ra_rdy_low", rdy, 0);
      RST = 1;
      @(negedge clk);
      chk("ra_rdy", rdy, 1);
      chk("ra_busy", busy, 0);
      chk("ra_db", DB, 8'h00);
      RST = 0;
      drive(16'hD020, 0, 8'h00);
      wait_rdy(n);
      chk("ra_waits", n, 2);
      chk("ra_old_data", DB, 8'h9C);
      RST = 1;
      drive(16'h0200, 1, 8'h33);
      RST = 0;
      chk("rp_db", DB, 8'h00);
      drive(16'h0200, 0, 8'h00);
      chk("rp_no_write", DB, 8'h5A);
      last_db = 8'h5A;
      for (int i = 0; i < 16; i++) begin
         mf[i] = 8'(i * 37 + 5);
         ms[i] = 8'(i * 91 + 3);
         drive(16'h0300 + 16'(i), 1, mf[i]);
         drive(16'hD040 + 16'(i), 1, ms[i]);
         wait_rdy(n);
      end
      for (int k = 0; k < 400; k++) begin
         automatic int s = $urandom_range(1);
         automatic int i = $urandom_range(15);
         automatic logic w = $urandom_range(3) == 0;
         automatic logic [7:0] d = 8'($urandom);
         drive(s ? 16'hD040 + 16'(i) : 16'h0300 + 16'(i), w, d);
         if (s) begin
            chk("st_busy", busy, 1);
            wait_rdy(n);
            chk("st_waits", n, 2);
         end else chk("st_rdy", rdy, 1);
         if (w) begin
            if (s) ms[i] = d;
            else mf[i] = d;
            exp_db = last_db;
         end else exp_db = s ? ms[i] : mf[i];
         chk("st_db", DB, exp_db);
         last_db = exp_db;
      end
      drive(16'hD080, 1, 8'h5D);
      chk("w0_wr_rdy", rdy_w0, 1);
      drive(16'hD080, 0, 8'h00);
      chk("w0_rd_rdy", rdy_w0, 1);
      chk("w0_rd_db", db_w0, 8'h5D);
      drive(16'h1234, 1, 8'h11);
      drive(16'h0234, 0, 8'h00);
      chk("wrap_db", db_aw, 8'h11);
      drive(16'h1234, 0, 8'h00);
      chk("wrap_db_hi", db_aw, 8'h11);
      drive(16'hF234, 1, 8'h6B);
      drive(16'h0234, 0, 8'h00);
      chk("wrap_db_f", db_aw, 8'h6B);
      chk("w0_never_low", 16'(w0_low), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
